// File: rtl/dmem_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_lsu_ctrl
//
// Load/store initiator between the core's memory-request stage and a
// byte-enabled, single-port data memory with a registered read port.
//
// Each cycle it accepts at most one byte, halfword or word request over a
// valid/ready handshake.
//
// Stores
//   Issued to memory in the same cycle they are accepted. The memory-side
//   outputs are purely combinational from the request.
//
// Loads
//   The read strobe is issued in the acceptance cycle. The response is
//   presented one cycle later: the lane is extracted from the memory read
//   register and then sign- or zero-extended.
//
// Misaligned or reserved-size accesses never reach memory:
//   - a load returns an error response;
//   - a store raises a one-cycle st_err pulse.
//
// Ports
//   clk, rst_n      clock and asynchronous active-low reset
//
//   Request channel
//     req_valid / req_ready   handshake
//     req_is_ld               1 = load, 0 = store
//     req_size                00 byte, 01 half, 10 word, 11 reserved
//     req_signed              sign-extend load result
//     req_addr                byte address (ADDR_WIDTH+2 bits)
//     req_wdata               right-justified store data
//     req_tag                 load tag
//
//   Load response channel
//     ld_valid / ld_ready     handshake
//     ld_data                 extended load data
//     ld_tag                  tag of the response
//     ld_err                  response is for a misaligned or reserved load
//
//   Store error
//     st_err                  one-cycle pulse for a dropped store
//
//   Memory port
//     mem_valid_st            write strobe
//     mem_spec_ld             read strobe
//     mem_we                  byte-lane write enables
//     mem_addr                word address
//     mem_din                 lane-replicated store data
//     mem_dout                read data register
// -----------------------------------------------------------------------------
module dmem_lsu_ctrl #(
   parameter int ADDR_WIDTH = 10,
   parameter int TAG_WIDTH  = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,

   // request channel
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_is_ld,
   input  logic [1:0]            req_size,
   input  logic                  req_signed,
   input  logic [ADDR_WIDTH+1:0] req_addr,
   input  logic [31:0]           req_wdata,
   input  logic [TAG_WIDTH-1:0]  req_tag,

   // load response channel
   output logic                  ld_valid,
   input  logic                  ld_ready,
   output logic [31:0]           ld_data,
   output logic [TAG_WIDTH-1:0]  ld_tag,
   output logic                  ld_err,

   // store error pulse
   output logic                  st_err,

   // data memory port
   output logic                  mem_valid_st,
   output logic                  mem_spec_ld,
   output logic [3:0]            mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_din,
   input  logic [31:0]           mem_dout
);

   // access sizes
   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   // response state: IDLE = nothing pending, RESP = response on ld_*
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RESP = 1'b1;

   // -------------------------------------------------------------------------
   // State and fields captured from an accepted load
   // -------------------------------------------------------------------------
   logic [0:0]           state_q;
   logic [1:0]           size_q;
   logic                 signed_q;
   logic [1:0]           offset_q;
   logic [TAG_WIDTH-1:0] tag_q;
   logic                 err_q;

   logic                 pending;
   logic [1:0]           req_offset;
   logic                 aligned;
   logic                 accept;
   logic                 ld_accept;
   logic                 st_accept;
   logic [3:0]           lane_we;
   logic [31:0]          lane_din;
   logic [7:0]           rd_byte;
   logic [15:0]          rd_half;
   logic [31:0]          rd_ext;

   assign pending    = (state_q == ST_RESP);
   assign req_offset = req_addr[1:0];

   // -------------------------------------------------------------------------
   // Request side
   // -------------------------------------------------------------------------

   // NOTE: every signal driven in an always_comb gets a default on entry, so
   // no path through the case statement can leave it unassigned and infer a
   // latch.
   always_comb begin
      aligned = 1'b0;
      case (req_size)
         SIZE_BYTE: aligned = 1'b1;
         SIZE_HALF: aligned = ~req_offset[0];
         SIZE_WORD: aligned = (req_offset == 2'b00);
         default:   aligned = 1'b0;
      endcase
   end

   // A slot frees up as soon as the pending response is being consumed, so
   // back-to-back loads run at one per cycle with ld_ready held high.
   assign req_ready = !pending || ld_ready;
   assign accept    = req_valid && req_ready;
   assign ld_accept = accept &&  req_is_ld;
   assign st_accept = accept && !req_is_ld;

   // Only an aligned access reaches memory. Loads and stores are mutually
   // exclusive by construction, so the two strobes can never coincide.
   assign mem_spec_ld  = ld_accept && aligned;
   assign mem_valid_st = st_accept && aligned;
   assign st_err       = st_accept && !aligned;

   assign mem_addr = req_addr[ADDR_WIDTH+1:2];

   // Store lanes: the data is replicated across all lanes so the memory only
   // needs the byte enables to pick the right one.
   always_comb begin
      lane_we  = 4'b0000;
      lane_din = req_wdata;
      case (req_size)
         SIZE_BYTE: begin
            lane_we  = 4'b0001 << req_offset;
            lane_din = {4{req_wdata[7:0]}};
         end
         SIZE_HALF: begin
            lane_we  = req_offset[1] ? 4'b1100 : 4'b0011;
            lane_din = {2{req_wdata[15:0]}};
         end
         SIZE_WORD: begin
            lane_we  = 4'b1111;
            lane_din = req_wdata;
         end
         default: begin
            lane_we  = 4'b0000;
            lane_din = req_wdata;
         end
      endcase
   end

   // Enables are gated by the write strobe. Loads, idle cycles, stalled
   // cycles and dropped stores therefore all present we = 0.
   assign mem_we  = mem_valid_st ? lane_we : 4'b0000;
   assign mem_din = lane_din;

   // -------------------------------------------------------------------------
   // Response state
   // -------------------------------------------------------------------------

   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every register samples its pre-edge value regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         size_q   <= SIZE_BYTE;
         signed_q <= 1'b0;
         offset_q <= 2'b00;
         tag_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         if (ld_accept) begin
            // A new load replaces a completing response in the same edge.
            state_q  <= ST_RESP;
            size_q   <= req_size;
            signed_q <= req_signed;
            offset_q <= req_offset;
            tag_q    <= req_tag;
            err_q    <= !aligned;
         end else if (pending && ld_ready) begin
            state_q  <= ST_IDLE;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Load data path
   // -------------------------------------------------------------------------

   // The memory read register holds its value until the next read strobe.
   // A store accepted while the response completes leaves it untouched.
   always_comb begin
      rd_byte = mem_dout[7:0];
      case (offset_q)
         2'd0:    rd_byte = mem_dout[7:0];
         2'd1:    rd_byte = mem_dout[15:8];
         2'd2:    rd_byte = mem_dout[23:16];
         default: rd_byte = mem_dout[31:24];
      endcase
   end

   assign rd_half = offset_q[1] ? mem_dout[31:16] : mem_dout[15:0];

   always_comb begin
      rd_ext = mem_dout;
      case (size_q)
         SIZE_BYTE: rd_ext = signed_q ? {{24{rd_byte[7]}}, rd_byte}
                                      : {24'h000000, rd_byte};
         SIZE_HALF: rd_ext = signed_q ? {{16{rd_half[15]}}, rd_half}
                                      : {16'h0000, rd_half};
         default:   rd_ext = mem_dout;
      endcase
   end

   assign ld_valid = pending;
   assign ld_tag   = tag_q;
   assign ld_err   = pending && err_q;

   // Error responses carry zero data. The memory was never read for them.
   assign ld_data  = err_q ? 32'h0000_0000 : rd_ext;

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_lsu_ctrl
//
// Bench for dmem_lsu_ctrl. It contains:
//   - a byte-enabled data memory with a registered read port;
//   - a table of single-request vectors;
//   - hand-written multi-cycle sequences;
//   - a randomized phase checked against a byte-array reference model.
// -----------------------------------------------------------------------------
module tb_dmem_lsu_ctrl;

   localparam int AW = 10;
   localparam int TW = 5;

   logic          clk;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic          req_is_ld;
   logic [1:0]    req_size;
   logic          req_signed;
   logic [AW+1:0] req_addr;
   logic [31:0]   req_wdata;
   logic [TW-1:0] req_tag;
   logic          ld_valid;
   logic          ld_ready;
   logic [31:0]   ld_data;
   logic [TW-1:0] ld_tag;
   logic          ld_err;
   logic          st_err;
   logic          mem_valid_st;
   logic          mem_spec_ld;
   logic [3:0]    mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_din;
   logic [31:0]   mem_dout;

   int checks   = 0;
   int failures = 0;

   dmem_lsu_ctrl #(.ADDR_WIDTH(AW), .TAG_WIDTH(TW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_is_ld    (req_is_ld),
      .req_size     (req_size),
      .req_signed   (req_signed),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_tag      (req_tag),
      .ld_valid     (ld_valid),
      .ld_ready     (ld_ready),
      .ld_data      (ld_data),
      .ld_tag       (ld_tag),
      .ld_err       (ld_err),
      .st_err       (st_err),
      .mem_valid_st (mem_valid_st),
      .mem_spec_ld  (mem_spec_ld),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_din      (mem_din),
      .mem_dout     (mem_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // -------------------------------------------------------------------------
   // Data memory: byte-lane writes, registered read held until the next read.
   // -------------------------------------------------------------------------
   logic [31:0] mem [0:(1<<AW)-1];
   logic        mem_clear;

   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
      end else begin
         if (mem_valid_st)
            for (int b = 0; b < 4; b++)
               if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
         if (mem_spec_ld) mem_dout <= mem[mem_addr];
      end
   end

   // -------------------------------------------------------------------------
   // Checking helper
   // -------------------------------------------------------------------------
   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // -------------------------------------------------------------------------
   // Vector table
   // -------------------------------------------------------------------------
   typedef struct packed {
      logic        is_ld;
      logic [1:0]  size;
      logic        sgn;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [4:0]  tag;
      logic [3:0]  exp_we;
      logic [31:0] exp_din;
      logic        exp_st;
      logic        exp_ld;
      logic        exp_st_err;
      logic [31:0] exp_data;
      logic        exp_err;
   } vec_t;

   function automatic vec_t mkv(
      input logic is_ld, input logic [1:0] size, input logic sgn,
      input logic [11:0] addr, input logic [31:0] wdata, input logic [4:0] tag,
      input logic [3:0] exp_we, input logic [31:0] exp_din, input logic exp_st,
      input logic exp_ld, input logic exp_st_err, input logic [31:0] exp_data,
      input logic exp_err);
      vec_t v;
      v.is_ld      = is_ld;
      v.size       = size;
      v.sgn        = sgn;
      v.addr       = addr;
      v.wdata      = wdata;
      v.tag        = tag;
      v.exp_we     = exp_we;
      v.exp_din    = exp_din;
      v.exp_st     = exp_st;
      v.exp_ld     = exp_ld;
      v.exp_st_err = exp_st_err;
      v.exp_data   = exp_data;
      v.exp_err    = exp_err;
      return v;
   endfunction

   task automatic idle_inputs();
      req_valid  = 1'b0;
      req_is_ld  = 1'b0;
      req_size   = 2'b00;
      req_signed = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      req_tag    = '0;
   endtask

   task automatic drive(input logic is_ld, input logic [1:0] size,
                        input logic sgn, input logic [11:0] addr,
                        input logic [31:0] wdata, input logic [4:0] tag);
      req_valid  = 1'b1;
      req_is_ld  = is_ld;
      req_size   = size;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wdata;
      req_tag    = tag;
   endtask

   // One request with ld_ready high.
   // Memory-side outputs are checked in the acceptance cycle; a load's
   // response is checked one cycle later.
   task automatic apply_vec(input vec_t v, input string nm);
      @(posedge clk); #1;
      ld_ready = 1'b1;
      drive(v.is_ld, v.size, v.sgn, v.addr, v.wdata, v.tag);
      @(negedge clk);
      check({nm, " req_ready"},   req_ready,    1);
      check({nm, " valid_st"},    mem_valid_st, v.exp_st);
      check({nm, " spec_ld"},     mem_spec_ld,  v.exp_ld);
      check({nm, " we"},          mem_we,       v.exp_we);
      check({nm, " st_err"},      st_err,       v.exp_st_err);
      check({nm, " addr"},        mem_addr,     v.addr[11:2]);
      if (v.exp_st) check({nm, " din"}, mem_din, v.exp_din);
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      if (v.is_ld) begin
         check({nm, " ld_valid"}, ld_valid, 1);
         check({nm, " ld_err"},   ld_err,   v.exp_err);
         check({nm, " ld_data"},  ld_data,  v.exp_data);
         check({nm, " ld_tag"},   ld_tag,   v.tag);
      end else begin
         check({nm, " st_err gone"}, st_err,   0);
         check({nm, " no resp"},     ld_valid, 0);
      end
   endtask

   task automatic single_load(input logic [11:0] addr, input logic [1:0] size,
                              input logic sgn, input logic [4:0] tag,
                              input logic [31:0] exp, input string nm);
      apply_vec(mkv(1'b1, size, sgn, addr, 32'h0, tag, 4'b0000, 32'h0,
                    1'b0, 1'b1, 1'b0, exp, 1'b0), nm);
   endtask

   vec_t vecs[16];

   // -------------------------------------------------------------------------
   // Reference model for the random phase: a byte array plus the expected
   // pending response.
   // -------------------------------------------------------------------------
   logic [7:0] ref_mem [0:63];

   function automatic bit ref_aligned(input int size, input int a);
      if (size == 0) return 1'b1;
      if (size == 1) return (a % 2) == 0;
      if (size == 2) return (a % 4) == 0;
      return 1'b0;
   endfunction

   function automatic logic [31:0] ref_load(input int size, input bit sgn,
                                            input int a);
      logic [31:0] v;
      if (size == 0) begin
         v = {24'h0, ref_mem[a]};
         if (sgn && ref_mem[a][7]) v = v | 32'hFFFF_FF00;
      end else if (size == 1) begin
         v = {16'h0, ref_mem[a+1], ref_mem[a]};
         if (sgn && ref_mem[a+1][7]) v = v | 32'hFFFF_0000;
      end else begin
         v = {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
      end
      return v;
   endfunction

   logic [31:0] b2b_data [4];
   logic [4:0]  b2b_tag  [4];

   initial begin
      bit          exp_pending;
      logic [31:0] exp_data;
      logic [4:0]  exp_tag;
      bit          exp_err;
      bit          exp_rdy;
      bit          acc;
      bit          al;
      int          sz;
      int          a;

      // ---------------------------------------------------------------------
      // Reset values
      // ---------------------------------------------------------------------
      rst_n     = 1'b0;
      ld_ready  = 1'b0;
      mem_clear = 1'b1;
      idle_inputs();
      #3;
      check("reset ld_valid",  ld_valid,  0);
      check("reset ld_err",    ld_err,    0);
      check("reset ld_tag",    ld_tag,    0);
      check("reset st_err",    st_err,    0);
      check("reset req_ready", req_ready, 1);
      check("reset strobes",   {mem_valid_st, mem_spec_ld}, 0);
      check("reset we",        mem_we,    0);
      @(posedge clk);
      @(posedge clk); #1;
      mem_clear = 1'b0;
      @(negedge clk);
      rst_n    = 1'b1;
      ld_ready = 1'b1;

      // ---------------------------------------------------------------------
      // Table of single requests
      // ---------------------------------------------------------------------
      vecs[0]  = mkv(0, 2'd2, 0, 12'h010, 32'hDEADBEEF, 5'd0,  4'b1111, 32'hDEADBEEF, 1, 0, 0, 32'h0, 0);
      vecs[1]  = mkv(1, 2'd2, 0, 12'h010, 32'h0,        5'd3,  4'b0000, 32'h0,        0, 1, 0, 32'hDEADBEEF, 0);
      vecs[2]  = mkv(0, 2'd0, 0, 12'h013, 32'h123456A5, 5'd0,  4'b1000, 32'hA5A5A5A5, 1, 0, 0, 32'h0, 0);
      vecs[3]  = mkv(1, 2'd0, 1, 12'h013, 32'h0,        5'd4,  4'b0000, 32'h0,        0, 1, 0, 32'hFFFFFFA5, 0);
      vecs[4]  = mkv(1, 2'd1, 0, 12'h012, 32'h0,        5'd5,  4'b0000, 32'h0,        0, 1, 0, 32'h0000A5AD, 0);
      vecs[5]  = mkv(1, 2'd1, 1, 12'h010, 32'h0,        5'd6,  4'b0000, 32'h0,        0, 1, 0, 32'hFFFFBEEF, 0);
      vecs[6]  = mkv(1, 2'd0, 0, 12'h011, 32'h0,        5'd7,  4'b0000, 32'h0,        0, 1, 0, 32'h000000BE, 0);
      vecs[7]  = mkv(0, 2'd1, 0, 12'h022, 32'hFFFF8001, 5'd0,  4'b1100, 32'h80018001, 1, 0, 0, 32'h0, 0);
      vecs[8]  = mkv(1, 2'd2, 0, 12'h020, 32'h0,        5'd8,  4'b0000, 32'h0,        0, 1, 0, 32'h80010000, 0);
      vecs[9]  = mkv(1, 2'd1, 0, 12'h011, 32'h0,        5'd9,  4'b0000, 32'h0,        0, 0, 0, 32'h0, 1);
      vecs[10] = mkv(0, 2'd2, 0, 12'h012, 32'h11111111, 5'd0,  4'b0000, 32'h0,        0, 0, 1, 32'h0, 0);
      vecs[11] = mkv(1, 2'd2, 0, 12'h010, 32'h0,        5'd10, 4'b0000, 32'h0,        0, 1, 0, 32'hA5ADBEEF, 0);
      vecs[12] = mkv(1, 2'd3, 0, 12'h010, 32'h0,        5'd11, 4'b0000, 32'h0,        0, 0, 0, 32'h0, 1);
      vecs[13] = mkv(0, 2'd3, 0, 12'h014, 32'h22222222, 5'd0,  4'b0000, 32'h0,        0, 0, 1, 32'h0, 0);
      vecs[14] = mkv(1, 2'd0, 1, 12'h012, 32'h0,        5'd12, 4'b0000, 32'h0,        0, 1, 0, 32'hFFFFFFAD, 0);
      vecs[15] = mkv(1, 2'd1, 1, 12'h022, 32'h0,        5'd13, 4'b0000, 32'h0,        0, 1, 0, 32'hFFFF8001, 0);
      for (int i = 0; i < 16; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

      // ---------------------------------------------------------------------
      // Read-after-write: store at t, load of the same word at t+1
      // ---------------------------------------------------------------------
      @(posedge clk); #1;
      drive(1'b0, 2'd2, 1'b0, 12'h030, 32'hCAFEF00D, 5'd0);
      @(negedge clk);
      check("raw store strobe", mem_valid_st, 1);
      @(posedge clk); #1;
      drive(1'b1, 2'd2, 1'b0, 12'h030, 32'h0, 5'd14);
      @(negedge clk);
      check("raw load strobe", mem_spec_ld, 1);
      check("raw load we",     mem_we,      0);
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      check("raw ld_valid", ld_valid, 1);
      check("raw ld_data",  ld_data,  32'hCAFEF00D);
      check("raw ld_tag",   ld_tag,   5'd14);

      // ---------------------------------------------------------------------
      // Backpressure: response held for 3 cycles while a store waits
      // ---------------------------------------------------------------------
      @(posedge clk); #1;
      ld_ready = 1'b0;
      drive(1'b1, 2'd2, 1'b0, 12'h010, 32'h0, 5'd15);
      @(posedge clk); #1;
      drive(1'b0, 2'd2, 1'b0, 12'h040, 32'h0BADC0DE, 5'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("bp%0d ld_valid", k),  ld_valid,  1);
         check($sformatf("bp%0d req_ready", k), req_ready, 0);
         check($sformatf("bp%0d strobes", k),   {mem_valid_st, mem_spec_ld}, 0);
         check($sformatf("bp%0d we", k),        mem_we,    0);
         check($sformatf("bp%0d ld_data", k),   ld_data,   32'hA5ADBEEF);
         check($sformatf("bp%0d ld_tag", k),    ld_tag,    5'd15);
         @(posedge clk); #1;
      end
      ld_ready = 1'b1;
      @(negedge clk);
      check("bp release req_ready", req_ready,    1);
      check("bp release ld_data",   ld_data,      32'hA5ADBEEF);
      check("bp release store",     mem_valid_st, 1);
      check("bp release we",        mem_we,       4'b1111);
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      check("bp done ld_valid", ld_valid, 0);
      single_load(12'h040, 2'd2, 1'b0, 5'd16, 32'h0BADC0DE, "bp reload");

      // ---------------------------------------------------------------------
      // Back-to-back loads, one per cycle
      // ---------------------------------------------------------------------
      b2b_data[0] = 32'hA5ADBEEF; b2b_tag[0] = 5'd20;
      b2b_data[1] = 32'hFFFFFFA5; b2b_tag[1] = 5'd21;
      b2b_data[2] = 32'hCAFEF00D; b2b_tag[2] = 5'd22;
      b2b_data[3] = 32'h00000BAD; b2b_tag[3] = 5'd23;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         case (i)
            0: drive(1'b1, 2'd2, 1'b0, 12'h010, 32'h0, b2b_tag[0]);
            1: drive(1'b1, 2'd0, 1'b1, 12'h013, 32'h0, b2b_tag[1]);
            2: drive(1'b1, 2'd2, 1'b0, 12'h030, 32'h0, b2b_tag[2]);
            default: drive(1'b1, 2'd1, 1'b0, 12'h042, 32'h0, b2b_tag[3]);
         endcase
         @(negedge clk);
         check($sformatf("b2b%0d req_ready", i), req_ready,   1);
         check($sformatf("b2b%0d spec_ld", i),   mem_spec_ld, 1);
         if (i > 0) begin
            check($sformatf("b2b%0d ld_valid", i - 1), ld_valid, 1);
            check($sformatf("b2b%0d ld_data", i - 1),  ld_data,  b2b_data[i-1]);
            check($sformatf("b2b%0d ld_tag", i - 1),   ld_tag,   b2b_tag[i-1]);
         end
      end
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      check("b2b3 ld_valid", ld_valid, 1);
      check("b2b3 ld_data",  ld_data,  b2b_data[3]);
      check("b2b3 ld_tag",   ld_tag,   b2b_tag[3]);

      // ---------------------------------------------------------------------
      // Asynchronous reset while a response is pending
      // ---------------------------------------------------------------------
      @(posedge clk); #1;
      ld_ready = 1'b0;
      drive(1'b1, 2'd2, 1'b0, 12'h030, 32'h0, 5'd24);
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      check("rst pending ld_valid", ld_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rst async ld_valid",  ld_valid,  0);
      check("rst async ld_tag",    ld_tag,    0);
      check("rst async ld_err",    ld_err,    0);
      check("rst async req_ready", req_ready, 1);
      @(posedge clk);
      @(negedge clk);
      rst_n    = 1'b1;
      ld_ready = 1'b1;
      check("rst after ld_valid", ld_valid, 0);
      single_load(12'h030, 2'd2, 1'b0, 5'd25, 32'hCAFEF00D, "rst reload");

      // ---------------------------------------------------------------------
      // Randomized traffic against the byte-array reference model
      // ---------------------------------------------------------------------
      @(posedge clk); #1;
      mem_clear = 1'b1;
      @(posedge clk); #1;
      mem_clear = 1'b0;
      for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
      exp_pending = 1'b0;
      exp_data    = '0;
      exp_tag     = '0;
      exp_err     = 1'b0;

      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clk); #1;
         req_valid  = ($urandom_range(0, 9) < 7);
         req_is_ld  = $urandom_range(0, 1) == 1;
         sz         = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
         req_size   = sz[1:0];
         req_signed = $urandom_range(0, 1) == 1;
         a          = $urandom_range(0, 63);
         req_addr   = a[11:0];
         req_wdata  = $urandom;
         req_tag    = 5'($urandom);
         ld_ready   = ($urandom_range(0, 3) != 0);

         @(negedge clk);
         check("rnd ld_valid", ld_valid, exp_pending);
         if (exp_pending) begin
            check("rnd ld_data", ld_data, exp_data);
            check("rnd ld_tag",  ld_tag,  exp_tag);
            check("rnd ld_err",  ld_err,  exp_err);
         end
         exp_rdy = !exp_pending || ld_ready;
         check("rnd req_ready", req_ready, exp_rdy);
         acc = req_valid && exp_rdy;
         al  = ref_aligned(sz, a);
         check("rnd valid_st", mem_valid_st, acc && !req_is_ld && al);
         check("rnd spec_ld",  mem_spec_ld,  acc &&  req_is_ld && al);
         check("rnd st_err",   st_err,       acc && !req_is_ld && !al);

         if (acc && !req_is_ld && al) begin
            for (int k = 0; k < (1 << sz); k++) ref_mem[a+k] = req_wdata[8*k +: 8];
         end
         if (acc && req_is_ld) begin
            exp_pending = 1'b1;
            exp_tag     = req_tag;
            exp_err     = !al;
            exp_data    = al ? ref_load(sz, req_signed, a) : 32'h0;
         end else if (exp_pending && ld_ready) begin
            exp_pending = 1'b0;
         end
      end

      @(posedge clk); #1;
      idle_inputs();
      ld_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("final ld_valid", ld_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_lsu_ctrl.md
# dmem_lsu_ctrl

Load/store initiator that drives the byte-enabled data-memory port (`valid_st`, `spec_ld`, `we`, `addr`, `din`, `dout`) from the core's memory-request stage. It accepts one byte, halfword or word request per cycle over a valid/ready handshake, and generates the word address, byte-lane write enables and lane-replicated store data. For loads, it extracts, aligns and sign/zero-extends the returned data and presents it on a tagged response channel with backpressure. Misaligned or unsupported accesses never touch memory; they produce an error response (load) or an error pulse (store).

## Interface
- `ADDR_WIDTH`, 10, word-address width of the data memory; the byte address is `ADDR_WIDTH+2` bits
- `TAG_WIDTH`, 5, width of the request tag returned with the load response
- Data path is fixed at 32 bits: 4 byte lanes of 8 bits.
- `clk`  in  1  sole clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  request accepted when `req_valid && req_ready`
- `req_is_ld`  in  1  1 = load, 0 = store
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 reserved
- `req_signed`  in  1  sign-extend load result
- `req_addr`  in  ADDR_WIDTH+2  byte address
- `req_wdata`  in  32  store data, right-justified
- `req_tag`  in  TAG_WIDTH  load tag
- `ld_valid`  out  1  load response valid
- `ld_ready`  in  1  consumer accepts response
- `ld_data`  out  32  extended load data
- `ld_tag`  out  TAG_WIDTH  tag of response
- `ld_err`  out  1  response is for a misaligned or reserved-size load
- `st_err`  out  1  one-cycle pulse: misaligned or reserved-size store dropped
- `mem_valid_st`, `mem_spec_ld`  out  1  memory write / read strobes
- `mem_we`  out  4  byte-lane enables
- `mem_addr`  out  ADDR_WIDTH  word address = `req_addr[ADDR_WIDTH+1:2]`
- `mem_din`  out  32  lane-replicated store data
- `mem_dout`  in  32  memory read register; valid the cycle after `spec_ld` and held until the next `spec_ld`

## Operation
- State is a single `pending` flag plus captured size, signed flag, byte offset, tag and error. The two states are IDLE (`pending`=0) and RESP (`pending`=1).
- `req_ready = !pending || ld_ready`. This applies to loads and stores alike.
- Aligned means: byte always; half when `addr[0]`=0; word when `addr[1:0]`=0. Size 11 is never aligned.
- **Accepted aligned store:**
  - `mem_valid_st`=1 in the same cycle; all memory-side outputs are combinational from the request.
  - Byte: `we`=1<<`addr[1:0]`, `din`={4{`wdata[7:0]`}}.
  - Half: `we`=`addr[1]`?1100:0011, `din`={2{`wdata[15:0]`}}.
  - Word: `we`=1111, `din`=`wdata`.
- **Accepted misaligned store:** `mem_valid_st`=0, `we`=0, and `st_err`=1 for that cycle only.
- **Accepted aligned load:** `mem_spec_ld`=1 and `we`=0. On the edge, `pending`←1 and `err`←0, and offset/size/signed/tag are captured.
- **Accepted misaligned load:** no memory strobe. `pending`←1 and `err`←1.
- `mem_spec_ld` and `mem_valid_st` are never asserted together.
- In RESP:
  - `ld_valid`=1.
  - `ld_data` is extracted combinationally from `mem_dout` using the captured offset and size: byte lane `offset`, half lane `offset[1]`, or full word. It is then zero- or sign-extended.
  - When `err`=1, `ld_data`=0.
- `ld_valid && ld_ready` with no new load accepted: `pending`←0. If a new load is accepted in the same cycle, `pending` stays 1 with the new fields.
- A store accepted while a response is completing does not disturb `mem_dout`; the response stays correct.

## Timing
- Load latency is 1: request accepted at cycle t, `ld_valid` at t+1.
- Throughput is one request per cycle with `ld_ready` held high, including back-to-back loads.
- Read-after-write: a store accepted at t followed by a load accepted at t+1 returns the new data.
- While `ld_valid && !ld_ready`: `ld_data`, `ld_tag` and `ld_err` are stable, `req_ready`=0, and all memory strobes are 0.
- Reset (asynchronous, at any time, including while `pending`=1): `pending`=0. The response is discarded and not replayed.
- Reset values of outputs: `ld_valid`=0, `ld_err`=0, `ld_tag`=0, `st_err`=0, `req_ready`=1. Memory strobes and `we` are 0 while `req_valid`=0.
- `ld_data` is don't-care while `ld_valid`=0.

## Test plan
- **Word store then load:** store word 0xDEADBEEF @0x010, then load word @0x010 the next cycle → `mem_we`=1111, `mem_addr`=4. `ld_valid` asserts 1 cycle after the load is accepted, with `ld_data`=0xDEADBEEF and tag echoed.
- **Sub-word lanes and extension:** after the word store, store byte 0xA5 @0x013 → `we`=1000, `din`=0xA5A5A5A5. Then:
  - signed byte load @0x013 → 0xFFFFFFA5
  - unsigned half load @0x012 → 0x0000A5AD
  - signed half load @0x010 → 0xFFFFBEEF
- **Backpressure:** load @0x010 with `ld_ready`=0 for 3 cycles while a store is offered → `req_ready`=0, no memory strobes, `ld_data` held. On release, the response completes and the store is accepted that cycle.
- **Misaligned accesses:**
  - half load @0x011 → no `spec_ld`; `ld_valid` with `ld_err`=1, `ld_data`=0
  - word store @0x012 → `st_err` pulse, `we`=0, memory unchanged (verify by reload)
- **Back-to-back loads:** 4 loads over 4 consecutive cycles with `ld_ready`=1 → 4 consecutive responses, in order, with correct tags.
- **Reset mid-operation:** assert `rst_n`=0 while `pending`=1 → `ld_valid` drops immediately (asynchronous reset); after release, `req_ready`=1 and the first new load returns correct data.
